// File: rtl/byte_serial_add_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
//   BYTE_W    : width of the shared adder slice
//   state_t   : controller state encoding
//   idx_width : width of the byte index counter for a given operand size
package byte_serial_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/byte_serial_add_seq_add8_slice.sv
// Combinational 8-bit ripple adder slice shared by all bytes of an operation.
//   a, b  : byte operands
//   cin   : carry in
//   sum   : byte sum
//   cout  : carry out of bit 7
module byte_serial_add_seq_add8_slice
    import byte_serial_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/byte_serial_add_seq.sv
// Wide add/subtract computed one byte per cycle, LSB first, through a single
// 8-bit adder slice with the carry chained through a register.
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_a, req_b, req_cin      : operands and carry-in (cin ignored on subtract)
//   req_sub                    : 1 = A - B
//   rsp_valid/rsp_ready        : response handshake
//   rsp_sum, rsp_cout, rsp_ovf : result, MSB carry out, signed overflow
//   busy                       : operation in progress or result pending
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// RUN   | one byte per cycle through the slice
// DONE  | result held until the consumer accepts it
module byte_serial_add_seq
    import byte_serial_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [NBYTES*BYTE_W-1:0] req_a,
    input  logic [NBYTES*BYTE_W-1:0] req_b,
    input  logic                     req_cin,
    input  logic                     req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [NBYTES*BYTE_W-1:0] rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf,
    output logic                     busy
);

    localparam int W     = NBYTES * BYTE_W;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    state_t            state, state_nxt;
    logic [W-1:0]      op_a, op_b, res;
    logic              carry, ovf_q;
    logic [IDX_W-1:0]  idx;
    logic              accept, last;
    logic [BYTE_W-1:0] slice_sum;
    logic              slice_cout;

    assign last = (idx == IDX_LAST);

    // Operands shift right each RUN cycle so the slice always sees byte 0;
    // the result shifts in from the top, so byte idx lands in its final
    // position once all NBYTES bytes have been processed.
    byte_serial_add_seq_add8_slice u_slice (
        .a    (op_a[BYTE_W-1:0]),
        .b    (op_b[BYTE_W-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            ovf_q <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            op_a  <= req_a;
            op_b  <= req_sub ? ~req_b : req_b;
            carry <= req_sub | req_cin;
            idx   <= '0;
        end else if (state == ST_RUN) begin
            op_a  <= op_a >> BYTE_W;
            op_b  <= op_b >> BYTE_W;
            res   <= {slice_sum, res[W-1:BYTE_W]};
            carry <= slice_cout;
            idx   <= idx + 1'b1;
            // On the last byte, bit 7 of the low operand bytes is the MSB
            // of the original (possibly inverted) operands.
            if (last)
                ovf_q <= (op_a[BYTE_W-1] == op_b[BYTE_W-1]) &&
                         (slice_sum[BYTE_W-1] != op_a[BYTE_W-1]);
        end
    end

    assign rsp_sum  = res;
    assign rsp_cout = carry;
    assign rsp_ovf  = ovf_q;

endmodule
